// File: rtl/sync_ram_ctrl.sv
// Single-port synchronous RAM with a request handshake, a registered read port and
// a hardware clear sweep that defines the contents after reset or on request.
module sync_ram_ctrl #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              addr_err,
    output logic              busy
);

    // state | meaning
    // INIT  | sweeping INIT_VAL into every word, requests refused
    // IDLE  | serving one read or write request per cycle
    typedef enum logic {INIT, IDLE} state_t;

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              in_range;
    logic              accept;

    assign in_range  = {1'b0, address} < DEPTH_EXT;
    assign req_ready = (state == IDLE) && !clear;
    assign accept    = req_valid && req_ready;
    assign busy      = (state == INIT);

    // Array carries no reset; the sweep is the only thing that defines it.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[ptr] <= INIT_VAL;
        end else if (accept && write_enable && in_range) begin
            mem[address] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            ptr      <= '0;
            data_out <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                INIT: begin
                    if (clear) begin
                        ptr <= '0;
                    end else if (ptr == LAST_PTR) begin
                        state <= IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                IDLE: begin
                    if (clear) begin
                        state <= INIT;
                        ptr   <= '0;
                    end else if (req_valid) begin
                        addr_err <= !in_range;
                        if (!write_enable) begin
                            rd_valid <= 1'b1;
                            data_out <= in_range ? mem[address] : '0;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Scoreboard bench for sync_ram_ctrl: a full-depth instance and a DEPTH=200 instance
// share clock and reset; per-request expectations are queued and checked on output.
`timescale 1ns/1ps
module tb_sync_ram_ctrl;

    typedef struct {
        int         due;
        bit         sel;
        bit         rv;
        bit         ae;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_a, req_valid_a, write_enable_a, req_ready_a, rd_valid_a, addr_err_a, busy_a;
    logic [7:0] address_a, data_in_a, data_out_a;
    logic       clear_b, req_valid_b, write_enable_b, req_ready_b, rd_valid_b, addr_err_b, busy_b;
    logic [7:0] address_b, data_in_b, data_out_b;

    int         n_chk  = 0;
    int         n_pass = 0;
    int         cyc    = 0;
    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [7:0] mdl [2][256];
    logic [7:0] last [2];
    int         n_busy, n_bad, n_rv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sync_ram_ctrl dut_a (
        .clk(clk), .rst(rst), .clear(clear_a), .req_valid(req_valid_a),
        .req_ready(req_ready_a), .write_enable(write_enable_a), .address(address_a),
        .data_in(data_in_a), .data_out(data_out_a), .rd_valid(rd_valid_a),
        .addr_err(addr_err_a), .busy(busy_a)
    );

    sync_ram_ctrl #(.DEPTH(200)) dut_b (
        .clk(clk), .rst(rst), .clear(clear_b), .req_valid(req_valid_b),
        .req_ready(req_ready_b), .write_enable(write_enable_b), .address(address_b),
        .data_in(data_in_b), .data_out(data_out_b), .rd_valid(rd_valid_b),
        .addr_err(addr_err_b), .busy(busy_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) mdl[s][i] = 8'h00;
            last[s] = 8'h00;
        end
    endtask

    task automatic drive_req(input bit sel, input bit we, input int a, input logic [7:0] d);
        exp_t e;
        bit   ok;
        @(posedge clk);
        #1;
        if (!sel) begin
            req_valid_a = 1'b1; write_enable_a = we; address_a = 8'(a); data_in_a = d;
        end else begin
            req_valid_b = 1'b1; write_enable_b = we; address_b = 8'(a); data_in_b = d;
        end
        ok     = sel ? (a < 200) : (a < 256);
        e.due  = cyc + 1;
        e.sel  = sel;
        e.rv   = !we;
        e.ae   = !ok;
        if (we) begin
            if (ok) mdl[sel][a] = d;
            e.data = last[sel];
        end else begin
            e.data    = ok ? mdl[sel][a] : 8'h00;
            last[sel] = e.data;
        end
        sb_q.push_back(e);
        #1 check_val("req_ready", sel ? req_ready_b : req_ready_a, 1);
    endtask

    task automatic idle_cycle(input bit sel);
        exp_t e;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        e.due  = cyc + 1;
        e.sel  = sel;
        e.rv   = 1'b0;
        e.ae   = 1'b0;
        e.data = last[sel];
        sb_q.push_back(e);
    endtask

    // Counts sweep cycles on dut_a from the next falling edge; outputs must stay quiet.
    task automatic count_busy(output int n, output int bad);
        n   = 0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy_a) break;
            n++;
            if (req_ready_a || rd_valid_a || addr_err_a || data_out_a !== last[0]) bad++;
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            if (mon_e.due != cyc) check_val("sb_late", cyc, mon_e.due);
            check_val("rd_valid", mon_e.sel ? rd_valid_b : rd_valid_a, mon_e.rv);
            check_val("addr_err", mon_e.sel ? addr_err_b : addr_err_a, mon_e.ae);
            check_val("data_out", mon_e.sel ? data_out_b : data_out_a, mon_e.data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        clear_a = 0; req_valid_a = 0; write_enable_a = 0; address_a = 0; data_in_a = 0;
        clear_b = 0; req_valid_b = 0; write_enable_b = 0; address_b = 0; data_in_b = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", busy_a, 1);
        check_val("rst_ready", req_ready_a, 0);
        check_val("rst_dout", data_out_a, 0);
        check_val("rst_rv", rd_valid_a, 0);

        // Power-up sweep, then first read
        rst = 1'b1;
        count_busy(n_busy, n_bad);
        check_val("sweep_len", n_busy, 256);
        check_val("sweep_quiet", n_bad, 0);
        drive_req(0, 0, 8'h05, 8'h00);
        idle_cycle(0);

        // Back-to-back writes and reads, write-then-read of the same word
        drive_req(0, 1, 0, 8'hFF);
        drive_req(0, 1, 2, 8'hAA);
        drive_req(0, 1, 3, 8'hF0);
        drive_req(0, 0, 0, 8'h00);
        drive_req(0, 0, 2, 8'h00);
        drive_req(0, 0, 3, 8'h00);
        drive_req(0, 1, 9, 8'h81);
        drive_req(0, 0, 9, 8'h00);
        drive_req(0, 1, 250, 8'h5A);
        drive_req(0, 0, 250, 8'h00);
        idle_cycle(0);

        // Out-of-range handling on the DEPTH=200 instance
        drive_req(1, 1, 250, 8'h55);
        drive_req(1, 0, 250, 8'h00);
        drive_req(1, 0, 50, 8'h00);
        drive_req(1, 1, 199, 8'h3C);
        drive_req(1, 0, 199, 8'h00);
        drive_req(1, 1, 200, 8'h66);
        drive_req(1, 0, 200, 8'h00);
        drive_req(1, 0, 0, 8'h00);
        idle_cycle(1);
        repeat (2) @(posedge clk);

        // Clear from IDLE with a competing write
        #1;
        clear_a = 1'b1; req_valid_a = 1'b1; write_enable_a = 1'b1; address_a = 8'd2; data_in_a = 8'h77;
        #1 check_val("clr_ready", req_ready_a, 0);
        @(posedge clk);
        #1;
        clear_a = 1'b0; req_valid_a = 1'b0;
        count_busy(n_busy, n_bad);
        check_val("clr_len", n_busy, 256);
        check_val("clr_quiet", n_bad, 0);
        for (int i = 0; i < 256; i++) mdl[0][i] = 8'h00;
        drive_req(0, 0, 2, 8'h00);
        drive_req(0, 0, 0, 8'h00);
        drive_req(0, 1, 7, 8'hC3);
        drive_req(0, 0, 7, 8'h00);
        idle_cycle(0);
        repeat (2) @(posedge clk);

        // Reset in the middle of a sweep
        #1 clear_a = 1'b1;
        @(posedge clk);
        #1 clear_a = 1'b0;
        repeat (100) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_val("mid_rst_busy", busy_a, 1);
        check_val("mid_rst_ready", req_ready_a, 0);
        check_val("mid_rst_dout", data_out_a, 0);
        check_val("mid_rst_rv", rd_valid_a, 0);
        model_reset();

        // Read held from reset release is taken once, in the first IDLE cycle
        req_valid_a = 1'b1; write_enable_a = 1'b0; address_a = 8'd3;
        @(posedge clk);
        #1 rst = 1'b1;
        count_busy(n_busy, n_bad);
        check_val("rst2_len", n_busy, 256);
        check_val("rst2_quiet", n_bad, 0);
        @(posedge clk);
        #1 req_valid_a = 1'b0;
        n_rv = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) check_val("held_rd_data", data_out_a, 8'h00);
            if (rd_valid_a) n_rv++;
        end
        check_val("held_rd_once", n_rv, 1);

        check_val("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
